// File: rtl/sa_tile_scheduler.sv
// Systolic-array tile scheduler: accepts a matmul job, walks output tiles in
// row-major order, sequences feeder start / PE clear / shift, drains the
// array skew and hands each finished tile downstream via valid/ready.
// All outputs are flops loaded from the next-state decode so they line up
// with the state they describe.
module sa_tile_scheduler #(
  parameter int X_R       = 16,
  parameter int W_C       = 16,
  parameter int T_W       = 4,
  parameter int DRAIN_CYC = X_R + W_C - 2
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RSTN,
  input  logic           I_REQ,
  input  logic           I_ABORT,
  input  logic [7:0]     I_M_DIM,
  input  logic [T_W-1:0] I_ROW_TILES,
  input  logic [T_W-1:0] I_COL_TILES,
  input  logic           I_MGR_OVER,
  input  logic           I_RES_READY,
  output logic           O_ACK,
  output logic           O_ERR,
  output logic           O_MGR_START,
  output logic           O_PE_CLR,
  output logic           O_PE_SHIFT,
  output logic [7:0]     O_M_DIM,
  output logic [T_W-1:0] O_ROW_IDX,
  output logic [T_W-1:0] O_COL_IDX,
  output logic           O_RES_VALID,
  output logic           O_BUSY,
  output logic           O_DONE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  localparam int               DRN_W      = (DRAIN_CYC < 2) ? 2 : $clog2(DRAIN_CYC + 1);
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYC);
  localparam logic [DRN_W-1:0] DRN_ONE    = DRN_W'(1'b1);
  localparam logic [DRN_W-1:0] DRN_ZERO   = DRN_W'(1'b0);
  localparam logic [T_W-1:0]   IDX_ONE    = T_W'(1'b1);
  localparam logic [T_W-1:0]   IDX_ZERO   = T_W'(1'b0);
  localparam logic [7:0]       M_DIM_MAX  = 8'd128;
  // feed counter starts at 0 in the first FEED cycle, so 129 marks the 130th
  localparam logic [7:0]       WDOG_LAST  = 8'd129;

  // A job is legal when the inner dimension is 1..128 and both tile counts are non-zero
  function automatic logic cfg_legal(input logic [7:0]     m,
                                     input logic [T_W-1:0] r,
                                     input logic [T_W-1:0] c);
    cfg_legal = (m != 8'd0) && (m <= M_DIM_MAX) && (r != IDX_ZERO) && (c != IDX_ZERO);
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       m_dim_q, m_dim_d;
  logic [T_W-1:0]   rows_q, rows_d, cols_q, cols_d;
  logic [T_W-1:0]   row_q, row_d, col_q, col_d;
  logic [7:0]       feed_cnt_q, feed_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             ack_q, ack_d, err_q, err_d, start_q, start_d, shift_q, shift_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic             cfg_ok, wdog_fire, last_col, last_row;

  assign cfg_ok    = cfg_legal(I_M_DIM, I_ROW_TILES, I_COL_TILES);
  // An exhausted feeder on the same cycle wins over the watchdog
  assign wdog_fire = (state_q == S_FEED) && !I_MGR_OVER && (feed_cnt_q == WDOG_LAST);
  assign last_col  = (col_q == (cols_q - IDX_ONE));
  assign last_row  = (row_q == (rows_q - IDX_ONE));

  // State register
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update; abort overrides every state
  always_comb begin
    state_d     = state_q;
    m_dim_d     = m_dim_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    row_d       = row_q;
    col_d       = col_q;
    feed_cnt_d  = feed_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (I_ABORT) begin
      state_d     = S_IDLE;
      m_dim_d     = 8'd0;
      rows_d      = IDX_ZERO;
      cols_d      = IDX_ZERO;
      row_d       = IDX_ZERO;
      col_d       = IDX_ZERO;
      feed_cnt_d  = 8'd0;
      drain_cnt_d = DRN_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_REQ && cfg_ok) begin
            m_dim_d = I_M_DIM;
            rows_d  = I_ROW_TILES;
            cols_d  = I_COL_TILES;
            row_d   = IDX_ZERO;
            col_d   = IDX_ZERO;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          feed_cnt_d = 8'd0;
          state_d    = S_FEED;
        end
        S_FEED: begin
          if (I_MGR_OVER) begin
            drain_cnt_d = DRAIN_INIT;
            state_d     = S_DRAIN;
          end else if (wdog_fire) begin
            row_d   = IDX_ZERO;
            col_d   = IDX_ZERO;
            state_d = S_IDLE;
          end else begin
            feed_cnt_d = feed_cnt_q + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q <= DRN_ONE) begin
            state_d = S_OUT;
          end else begin
            drain_cnt_d = drain_cnt_q - DRN_ONE;
          end
        end
        S_OUT: begin
          if (I_RES_READY) begin
            if (!last_col) begin
              col_d   = col_q + IDX_ONE;
              state_d = S_LOAD;
            end else if (!last_row) begin
              row_d   = row_q + IDX_ONE;
              col_d   = IDX_ZERO;
              state_d = S_LOAD;
            end else begin
              row_d   = IDX_ZERO;
              col_d   = IDX_ZERO;
              state_d = S_FIN;
            end
          end else begin
            state_d = S_OUT;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the output flops match it
  always_comb begin
    ack_d   = (state_q == S_IDLE) && (state_d == S_LOAD);
    start_d = (state_d == S_LOAD);
    shift_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    if (I_ABORT) begin
      err_d = 1'b0;
    end else if ((state_q == S_IDLE) && I_REQ && !cfg_ok) begin
      err_d = 1'b1;
    end else if (wdog_fire) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  // Job configuration, tile indices and cycle counters
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      m_dim_q     <= 8'd0;
      rows_q      <= IDX_ZERO;
      cols_q      <= IDX_ZERO;
      row_q       <= IDX_ZERO;
      col_q       <= IDX_ZERO;
      feed_cnt_q  <= 8'd0;
      drain_cnt_q <= DRN_ZERO;
    end else begin
      m_dim_q     <= m_dim_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Registered control outputs
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O_ACK       = ack_q;
  assign O_ERR       = err_q;
  assign O_MGR_START = start_q;
  assign O_PE_CLR    = start_q;
  assign O_PE_SHIFT  = shift_q;
  assign O_M_DIM     = m_dim_q;
  assign O_ROW_IDX   = row_q;
  assign O_COL_IDX   = col_q;
  assign O_RES_VALID = valid_q;
  assign O_BUSY      = busy_q;
  assign O_DONE      = done_q;

endmodule

// File: doc/sa_tile_scheduler.md
Name: sa_tile_scheduler

Overview:
Sequencing controller for the systolic-array matmul datapath.
- Accepts a job: inner dimension plus row/column tile counts.
- Walks the output tiles in row-major order.
- Drives the operand-feeder start/shift controls and drains the PE array.
- Hands each finished tile downstream with a valid/ready handshake.
- Sits between the attention-layer control FSM and the matrix feeder + PE array.

Parameters:
X_R, 16, array rows (X operand vector length)
W_C, 16, array columns (W operand vector length)
T_W, 4, width of tile-count/tile-index fields
DRAIN_CYC, X_R+W_C-2, post-feed shift cycles needed to flush the array skew

Ports:
I_CLK  in  1  clock
I_ASYN_RSTN  in  1  reset, asynchronous, active-low
I_REQ  in  1  job request, level, sampled only in IDLE
I_ABORT  in  1  synchronous abort, any state
I_M_DIM  in  8  inner dimension, legal 1..128
I_ROW_TILES  in  T_W  row tile count, legal >=1
I_COL_TILES  in  T_W  column tile count, legal >=1
I_MGR_OVER  in  1  feeder exhausted flag (registered in feeder)
I_RES_READY  in  1  downstream accepts tile result
O_ACK  out  1  1-cycle pulse, job accepted
O_ERR  out  1  1-cycle pulse, job rejected or watchdog fired
O_MGR_START  out  1  feeder restart pulse
O_PE_CLR  out  1  PE accumulator clear, coincident with O_MGR_START
O_PE_SHIFT  out  1  shift enable to feeder and PE array
O_M_DIM  out  8  latched inner dimension to feeder
O_ROW_IDX  out  T_W  current tile row, for operand fetch
O_COL_IDX  out  T_W  current tile column
O_RES_VALID  out  1  tile result valid
O_BUSY  out  1  job in progress
O_DONE  out  1  1-cycle pulse, last tile accepted

Behaviour:
Reset:
- State = IDLE; all outputs 0; indices 0; O_M_DIM 0.
- Asynchronous reset mid-job discards the job with no O_DONE.

States: IDLE, LOAD, FEED, DRAIN, OUT, FIN.

IDLE:
- When I_REQ=1 and the config is legal, latch M_DIM/ROW_TILES/COL_TILES, set row=col=0, go to LOAD.
- O_ACK is high during the first LOAD cycle of the job only.
- Config is illegal when M_DIM==0, M_DIM>128, ROW_TILES==0 or COL_TILES==0. Then pulse O_ERR the next cycle and stay in IDLE.
- Inputs that change after acceptance are ignored.

LOAD (1 cycle):
- O_MGR_START=1, O_PE_CLR=1, O_PE_SHIFT=0.
- Go to FEED.

FEED:
- O_PE_SHIFT=1 every cycle.
- Exit to DRAIN on the first cycle I_MGR_OVER=1 is sampled. I_MGR_OVER from a previous tile is never sampled in LOAD.
- Nominal duration is M_DIM+1 cycles.
- Watchdog: if FEED reaches 130 cycles, pulse O_ERR and go to IDLE.

DRAIN:
- O_PE_SHIFT=1 for exactly DRAIN_CYC cycles (down-counter), then go to OUT.

OUT:
- O_RES_VALID=1, O_PE_SHIFT=0; the array is frozen.
- O_RES_VALID holds until I_RES_READY=1.
- On handshake:
  - if col<COL_TILES-1: col++, go to LOAD.
  - else if row<ROW_TILES-1: row++, col=0, go to LOAD.
  - else go to FIN.
- Indices change only on the handshake edge.

FIN (1 cycle):
- O_DONE=1; indices cleared; go to IDLE.

O_BUSY = (state != IDLE).

Tile timing:
- If I_REQ is sampled at edge 0, LOAD is cycle 1.
- O_RES_VALID first rises in cycle M_DIM+DRAIN_CYC+3. Example: M_DIM=4, X_R=W_C=16 gives cycle 37.
- Each subsequent tile starts LOAD the cycle after the handshake.

I_ABORT:
- Highest priority after reset.
- Next state is IDLE from any state; all pulses suppressed; indices cleared; no O_DONE, no O_ERR.
- I_ABORT together with I_REQ in IDLE: abort wins, no accept.

I_REQ held high after FIN starts a new job immediately, with a fresh O_ACK.

Test Plan:
1. Reset release, then I_REQ with M_DIM=4, ROW=COL=1; feeder model asserts OVER after 4 shifts → O_ACK and O_MGR_START in cycle 1, O_PE_SHIFT high cycles 2-36, O_RES_VALID at cycle 37; with I_RES_READY=1, O_DONE at cycle 38, O_BUSY low at 39.
2. ROW=2, COL=3, M_DIM=128 → 6 tiles; (row,col) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); O_PE_CLR pulses 6 times; exactly one O_DONE.
3. I_RES_READY held low 10 cycles in OUT → O_RES_VALID stays high, O_PE_SHIFT stays low, indices stable; advance occurs the cycle after READY rises.
4. Illegal configs M_DIM=0, M_DIM=129, COL_TILES=0 → O_ERR 1-cycle pulse each, O_ACK never asserted, O_BUSY stays 0.
5. I_ABORT in DRAIN of tile (0,1) → next cycle IDLE, all outputs 0, no O_DONE; following legal request restarts at (0,0).
6. Feeder model never asserts OVER → O_ERR after 130 FEED cycles, return to IDLE; async reset asserted mid-FEED → all outputs 0 immediately.
